// File: rtl/burst_io_pkg.sv
// Shared types, constants and sizing helpers for burst_io_ctrl and its channel generator.
package burst_io_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_CALC,
    CH_REQ,
    CH_FIN
  } chan_state_e;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  localparam int unsigned PAGE_BYTES = 4096;

  // ceil(length / 2**shift) without forming length + beat - 1, so it cannot overflow.
  function automatic logic [63:0] beat_count(input logic [63:0] length,
                                             input int unsigned shift);
    logic [63:0] mask;
    mask = (64'd1 << shift) - 64'd1;
    return (length >> shift) + {63'd0, |(length & mask)};
  endfunction

  function automatic logic [8:0] burst_size(input logic [63:0]  remaining,
                                            input logic [11:0]  page_off,
                                            input int unsigned  shift,
                                            input int unsigned  max_beats);
    logic [63:0] lim;
    logic [63:0] room;
    room = (64'(PAGE_BYTES) - {52'd0, page_off}) >> shift;
    lim  = 64'(max_beats);
    if (room < lim)      lim = room;
    if (remaining < lim) lim = remaining;
    return lim[8:0];
  endfunction

endpackage

// File: rtl/burst_io_ctrl_chan.sv
// burst_chan_gen: one channel's burst generator; splits a job into requests that
// never exceed MAX_BEATS beats nor cross a 4 KB page.
module burst_chan_gen
  import burst_io_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int LEN_W      = 35,
  parameter int BEAT_BYTES = 64,
  parameter int MAX_BEATS  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              done_out,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              req,
  input  logic              ack,
  output logic [7:0]        len,
  output logic [ADDR_W-1:0] address,
  output logic              fin
);

  localparam int unsigned      BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << BEAT_SHIFT) - ADDR_W'(1));

  chan_state_e      state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] remaining_after;
  logic [8:0]       burst;
  logic [8:0]       burst_calc;

  assign burst_calc      = burst_size(64'(remaining), address[11:0], BEAT_SHIFT, MAX_BEATS);
  assign remaining_after = remaining - LEN_W'(burst);
  assign req             = (state == CH_REQ);
  assign fin             = (state == CH_FIN);

  // NOTE: registered state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CH_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      CH_IDLE: if (start) state_nxt = CH_CALC;
      CH_CALC: begin
        if (remaining == '0) state_nxt = CH_FIN;
        else if (!stall)     state_nxt = CH_REQ;
      end
      CH_REQ:  if (ack) state_nxt = (remaining_after == '0) ? CH_FIN : CH_CALC;
      CH_FIN: begin
        // A start can land in the cycle idle rises, before FIN has seen done_out.
        if (start)         state_nxt = CH_CALC;
        else if (done_out) state_nxt = CH_IDLE;
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address   <= '0;
      remaining <= '0;
      burst     <= '0;
      len       <= '0;
    end else begin
      unique case (state)
        CH_IDLE, CH_FIN: begin
          if (start) begin
            address   <= base_addr & ALIGN_MASK;
            remaining <= LEN_W'(beat_count(64'(length), BEAT_SHIFT));
          end
        end
        CH_CALC: begin
          if (remaining != '0 && !stall) begin
            burst <= burst_calc;
            len   <= burst_calc[7:0] - 8'd1;
          end
        end
        CH_REQ: begin
          if (ack) begin
            address   <= address + (ADDR_W'(burst) << BEAT_SHIFT);
            remaining <= remaining_after;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/burst_io_ctrl.sv
// burst_io_ctrl: read/write job front end with write-response tracking and completion.
// Define BURST_IO_PERF_CNT_EN to add the busy_cycles and wr_bursts counters.
module burst_io_ctrl
  import burst_io_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int LEN_W      = 35,
  parameter int BEAT_BYTES = 64,
  parameter int MAX_BEATS  = 64,
  parameter int OUTST_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  rd_length,
  input  logic [ADDR_W-1:0] des_addr,
  input  logic [LEN_W-1:0]  wr_length,
  output logic              rd_req,
  input  logic              rd_req_ack,
  output logic [7:0]        rd_len,
  output logic [ADDR_W-1:0] rd_address,
  output logic              wr_req,
  input  logic              wr_req_ack,
  output logic [7:0]        wr_len,
  output logic [ADDR_W-1:0] wr_address,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  input  logic              core_done,
  output logic              idle,
  output logic              ready,
  output logic              done_out,
  output logic              error
`ifdef BURST_IO_PERF_CNT_EN
  ,
  output logic [31:0]       busy_cycles,
  output logic [31:0]       wr_bursts
`endif
);

  logic               start_acc;
  logic               rd_fin, wr_fin;
  logic               wr_hs, b_hs, b_count;
  logic               core_seen;
  logic               all_done;
  logic [OUTST_W-1:0] outst;

  assign start_acc = start & idle;
  assign wr_hs     = wr_req & wr_req_ack;
  assign b_hs      = bvalid & bready;
  assign b_count   = b_hs & (outst != '0);
  assign all_done  = rd_fin & wr_fin & (outst == '0) & core_seen & ~done_out;

  burst_chan_gen #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BEAT_BYTES(BEAT_BYTES), .MAX_BEATS(MAX_BEATS)
  ) u_rd (
    .clk(clk), .rst_n(rst_n), .start(start_acc), .stall(1'b0), .done_out(done_out),
    .base_addr(src_addr), .length(rd_length),
    .req(rd_req), .ack(rd_req_ack), .len(rd_len), .address(rd_address), .fin(rd_fin)
  );

  burst_chan_gen #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BEAT_BYTES(BEAT_BYTES), .MAX_BEATS(MAX_BEATS)
  ) u_wr (
    .clk(clk), .rst_n(rst_n), .start(start_acc), .stall(&outst), .done_out(done_out),
    .base_addr(des_addr), .length(wr_length),
    .req(wr_req), .ack(wr_req_ack), .len(wr_len), .address(wr_address), .fin(wr_fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle      <= 1'b1;
      ready     <= 1'b0;
      bready    <= 1'b0;
      done_out  <= 1'b0;
      error     <= 1'b0;
      core_seen <= 1'b0;
      outst     <= '0;
    end else begin
      ready <= 1'b1;
      if (start_acc) begin
        idle      <= 1'b0;
        bready    <= 1'b1;
        done_out  <= 1'b0;
        error     <= 1'b0;
        core_seen <= 1'b0;
        outst     <= '0;
      end else begin
        if (core_done) core_seen <= 1'b1;
        if (b_hs && bresp != BRESP_OKAY) error <= 1'b1;
        // A response with nothing outstanding is not counted; simultaneous +1/-1 cancel.
        if (wr_hs && !b_count)      outst <= outst + OUTST_W'(1);
        else if (b_count && !wr_hs) outst <= outst - OUTST_W'(1);
        if (all_done) begin
          done_out <= 1'b1;
          idle     <= 1'b1;
          bready   <= 1'b0;
        end
      end
    end
  end

`ifdef BURST_IO_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles <= '0;
      wr_bursts   <= '0;
    end else if (start_acc) begin
      busy_cycles <= '0;
      wr_bursts   <= '0;
    end else begin
      if (!idle && !(&busy_cycles)) busy_cycles <= busy_cycles + 32'd1;
      if (wr_hs && !(&wr_bursts))   wr_bursts   <= wr_bursts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_burst_io_ctrl.sv
// Randomized self-checking bench for burst_io_ctrl against a burst-list reference model.
`timescale 1ns/1ps
module tb_burst_io_ctrl;

  localparam int ADDR_W = 64;
  localparam int LEN_W  = 35;
  localparam longint unsigned BB   = 64;
  localparam longint unsigned MAXB = 64;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0, des_addr = '0;
  logic [LEN_W-1:0]  rd_length = '0, wr_length = '0;
  logic              rd_req, wr_req, bready, idle, ready, done_out, error;
  logic              rd_req_ack = 1'b0, wr_req_ack = 1'b0, bvalid = 1'b0, core_done = 1'b0;
  logic [1:0]        bresp = 2'b00;
  logic [7:0]        rd_len, wr_len;
  logic [ADDR_W-1:0] rd_address, wr_address;

  always #5 clk = ~clk;

  burst_io_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .rd_length(rd_length), .des_addr(des_addr), .wr_length(wr_length),
    .rd_req(rd_req), .rd_req_ack(rd_req_ack), .rd_len(rd_len), .rd_address(rd_address),
    .wr_req(wr_req), .wr_req_ack(wr_req_ack), .wr_len(wr_len), .wr_address(wr_address),
    .bvalid(bvalid), .bresp(bresp), .bready(bready), .core_done(core_done),
    .idle(idle), .ready(ready), .done_out(done_out), .error(error)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } burst_t;

  burst_t rd_exp[$];
  burst_t wr_exp[$];
  int     b_due[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the job in bytes, cutting at MAX_BEATS and at each 4 KB page end.
  task automatic plan(input logic [63:0] base, input logic [63:0] length, input bit is_wr);
    logic [63:0] a, beats, room, n;
    burst_t b;
    a     = base & ~(BB - 1);
    beats = (length + BB - 1) / BB;
    while (beats != 0) begin
      room = (4096 - (a % 4096)) / BB;
      n = beats;
      if (n > MAXB) n = MAXB;
      if (n > room) n = room;
      b.addr = a;
      b.len  = 8'(n - 1);
      if (is_wr) wr_exp.push_back(b);
      else       rd_exp.push_back(b);
      a     = a + n * BB;
      beats = beats - n;
    end
  endtask

  task automatic run_job(input logic [63:0] src, input logic [LEN_W-1:0] rdl,
                         input logic [63:0] des, input logic [LEN_W-1:0] wrl,
                         input int ack_max, input int b_min, input int b_max,
                         input int err_idx, input string name);
    int cyc, rd_wait, wr_wait, first_rd, first_wr, last_evt, n_resp, model_outst, pre;
    bit core_sent, exp_err, rd_any, wr_any, got_done, hs;
    rd_exp.delete();
    wr_exp.delete();
    b_due.delete();
    plan(src, 64'(rdl), 1'b0);
    plan(des, 64'(wrl), 1'b1);
    rd_any  = rd_exp.size() > 0;
    wr_any  = wr_exp.size() > 0;
    exp_err = (err_idx >= 0) && (err_idx < wr_exp.size());

    @(negedge clk);
    start = 1'b1; src_addr = src; rd_length = rdl; des_addr = des; wr_length = wrl;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({name, ":start_state"}, 64'({idle, done_out, error, bready}), 64'(4'b0001));

    rd_wait = -1; wr_wait = -1; first_rd = -1; first_wr = -1;
    last_evt = 2; n_resp = 0; model_outst = 0;
    core_sent = 1'b0; got_done = 1'b0;
    while (cyc < BUDGET && !got_done) begin
      start = 1'b0;
      hs  = 1'b0;
      pre = model_outst;
      if (rd_req_ack) begin
        rd_req_ack = 1'b0;
        check({name, ":rd_req_drop"}, 64'(rd_req), 0);
        last_evt = cyc;
      end
      if (wr_req_ack) begin
        wr_req_ack = 1'b0;
        check({name, ":wr_req_drop"}, 64'(wr_req), 0);
        model_outst++;
        b_due.push_back(cyc + int'($urandom_range(b_max, b_min)));
        last_evt = cyc;
        hs = 1'b1;
      end
      if (bvalid) begin
        bvalid = 1'b0;
        if (pre > 0) model_outst--;
        last_evt = cyc;
        hs = 1'b1;
      end
      if (core_done) begin
        core_done = 1'b0;
        last_evt = cyc;
      end
      if (hs) check({name, ":outstanding"}, 64'(dut.outst), 64'(model_outst));

      if (done_out) begin
        got_done = 1'b1;
        check({name, ":done_cycle"}, 64'(cyc), 64'(last_evt + 1));
        check({name, ":done_idle_bready"}, 64'({idle, bready}), 64'(2'b10));
        check({name, ":error"}, 64'(error), 64'(exp_err));
        check({name, ":bursts_left"}, 64'(rd_exp.size() + wr_exp.size() + b_due.size()), 0);
      end else begin
        if (cyc == 2) begin
          start = 1'b1;
          src_addr = {$urandom, $urandom}; des_addr = {$urandom, $urandom};
          rd_length = 35'($urandom); wr_length = 35'($urandom);
        end
        if (rd_req) begin
          if (first_rd < 0) first_rd = cyc;
          if (rd_exp.size() == 0) begin
            check({name, ":rd_unexpected_req"}, 64'(rd_req), 0);
            rd_req_ack = 1'b1;
          end else begin
            if (rd_wait < 0) rd_wait = int'($urandom_range(ack_max, 0));
            if (rd_wait == 0) begin
              check({name, ":rd_len"}, 64'(rd_len), 64'(rd_exp[0].len));
              check({name, ":rd_address"}, rd_address, rd_exp[0].addr);
              void'(rd_exp.pop_front());
              rd_req_ack = 1'b1;
              rd_wait = -1;
            end else rd_wait--;
          end
        end
        if (wr_req) begin
          if (first_wr < 0) first_wr = cyc;
          if (wr_exp.size() == 0) begin
            check({name, ":wr_unexpected_req"}, 64'(wr_req), 0);
            wr_req_ack = 1'b1;
          end else begin
            if (wr_wait < 0) wr_wait = int'($urandom_range(ack_max, 0));
            if (wr_wait == 0) begin
              check({name, ":wr_len"}, 64'(wr_len), 64'(wr_exp[0].len));
              check({name, ":wr_address"}, wr_address, wr_exp[0].addr);
              void'(wr_exp.pop_front());
              wr_req_ack = 1'b1;
              wr_wait = -1;
            end else wr_wait--;
          end
        end
        if (b_due.size() > 0 && b_due[0] <= cyc) begin
          check({name, ":bready_busy"}, 64'(bready), 1);
          bvalid = 1'b1;
          bresp  = (n_resp == err_idx) ? 2'b10 : 2'b00;
          n_resp++;
          void'(b_due.pop_front());
        end
        if (!core_sent && rd_exp.size() == 0 && wr_exp.size() == 0 && !rd_req_ack && !wr_req_ack) begin
          core_done = 1'b1;
          core_sent = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!got_done) check({name, ":done_timeout"}, 64'(done_out), 1);
    if (rd_any) check({name, ":rd_first_latency"}, 64'(first_rd), 2);
    if (wr_any) check({name, ":wr_first_latency"}, 64'(first_wr), 2);
    check({name, ":done_held"}, 64'({done_out, idle}), 64'(2'b11));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check("reset_flags", 64'({idle, ready, rd_req, wr_req, bready, done_out, error}), 64'(7'b1000000));
    check("reset_lens", 64'({rd_len, wr_len}), 0);
    check("reset_addrs", rd_address | wr_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'({ready, idle}), 64'(2'b11));

    run_job(64'h1000, 35'd4096,  64'h0,    35'd0,    0, 0,  0, -1, "one_read");
    run_job(64'h0,    35'd10000, 64'h0,    35'd0,    2, 0,  0, -1, "three_reads");
    run_job(64'h0FC0, 35'd256,   64'h0,    35'd0,    1, 0,  0, -1, "page_split");
    run_job(64'h0,    35'd0,     64'h8000, 35'd8192, 0, 20, 20, 1, "wr_late_err");
    run_job(64'h0,    35'd0,     64'h3000, 35'd8192, 0, 1,  1, -1, "ack_b_same_cycle");

    for (int i = 0; i < 12; i++) begin
      run_job({32'($urandom_range(255, 0)), $urandom}, 35'($urandom_range(20000, 0)),
              {32'($urandom_range(255, 0)), $urandom}, 35'($urandom_range(20000, 0)),
              int'($urandom_range(3, 0)), 0, 6, int'($urandom_range(5, 0)) - 1,
              $sformatf("rand%0d", i));
    end

    @(negedge clk);
    start = 1'b1; src_addr = 64'h1000; rd_length = 35'd4096; des_addr = 64'h9000; wr_length = 35'd8192;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !rd_req; i++) @(negedge clk);
    check("rst_mid_req_seen", 64'({rd_req, wr_req}), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_async", 64'({rd_req, wr_req, idle, done_out, bready}), 64'(5'b00100));
    @(negedge clk);
    check("rst_mid_ready", 64'(ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(64'h1000, 35'd4096, 64'h0, 35'd0, 0, 0, 0, -1, "rerun_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
